// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state types and bit-mixing helpers.
package sha256_pkg;

  // Eight 32-bit words, element 0 (H0 / a) in the most significant slot.
  typedef logic [0:7][31:0] hash_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_OUT
  } state_e;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule small sigmas.
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression big sigmas and boolean mixers.
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message window: loads the block, then replays it and appends expanded words.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_wdata,
  input  logic        i_shift,
  input  logic        i_exp_sel,
  output logic [31:0] o_w
);

  // r_win[0] is the oldest word; for t>=16 the window holds W[t-16..t-1].
  logic [31:0] r_win [0:15];
  logic [31:0] w_exp;
  logic [31:0] w_push;

  assign w_exp  = s1(r_win[14]) + r_win[9] + s0(r_win[1]) + r_win[0];
  assign o_w    = i_exp_sel ? w_exp : r_win[0];
  // During rounds 0..15 the stored word is pushed back, so the window
  // naturally holds W[0..15] when expansion starts at t=16.
  assign w_push = i_load ? i_wdata : o_w;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      if (gi == 15) begin : g_tail
        // Newest slot takes the loaded or freshly scheduled word.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n)               r_win[gi] <= '0;
          else if (i_load || i_shift) r_win[gi] <= w_push;
        end
      end else begin : g_body
        // Every other slot shifts one place toward the oldest end.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n)               r_win[gi] <= '0;
          else if (i_load || i_shift) r_win[gi] <= r_win[gi + 1];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the working variables a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t       i_state,
  input  logic [31:0] i_w,
  input  logic [31:0] i_k,
  output hash_t       o_state
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_state[7] + bs1(i_state[4]) + ch(i_state[4], i_state[5], i_state[6]) + i_k + i_w;
  assign w_t2 = bs0(i_state[0]) + maj(i_state[0], i_state[1], i_state[2]);

  assign o_state = {w_t1 + w_t2, i_state[0], i_state[1], i_state[2],
                    i_state[3] + w_t1, i_state[4], i_state[5], i_state[6]};

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: word intake, 64 rounds, chaining add, digest handoff.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         i_wvalid,
  output logic         o_wready,
  input  logic [31:0]  i_wdata,
  input  logic         i_first,
  output logic         o_dvalid,
  input  logic         i_dready,
  output logic [255:0] o_digest,
  output logic         o_busy
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_e      r_state;
  logic [5:0]  r_t;       // word index in LOAD, round index in ROUND
  logic        r_first;
  hash_t       r_hash;
  hash_t       r_wv;
  logic        r_wready;
  logic        r_dvalid;
  logic        r_busy;

  logic        w_whs;
  logic        w_dhs;
  logic        w_shift;
  logic        w_exp_sel;
  logic [31:0] w_w;
  hash_t       w_round;
  hash_t       w_final;

  // r_wready is only ever set in IDLE/LOAD, so it alone qualifies the handshake.
  assign w_whs     = i_wvalid & r_wready;
  assign w_dhs     = r_dvalid & i_dready;
  assign w_shift   = (r_state == ST_ROUND);
  assign w_exp_sel = (r_t >= 6'd16);

  sha256_msg_sched u_sched (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_load    (w_whs),
    .i_wdata   (i_wdata),
    .i_shift   (w_shift),
    .i_exp_sel (w_exp_sel),
    .o_w       (w_w)
  );

  sha256_round u_round (
    .i_state (r_wv),
    .i_w     (w_w),
    .i_k     (K_TABLE[r_t]),
    .o_state (w_round)
  );

  // Chaining add; a first block always chains from IV regardless of stored H.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_final
      assign w_final[gi] = (r_first ? IV[gi] : r_hash[gi]) + r_wv[gi];
    end
  endgenerate

  // Block sequencer with registered handshake and status outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= ST_IDLE;
      r_t      <= '0;
      r_first  <= 1'b0;
      r_hash   <= IV;
      r_wv     <= IV;
      r_wready <= 1'b0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wready <= 1'b1;
          if (w_whs) begin
            r_state <= ST_LOAD;
            r_t     <= 6'd1;
            r_first <= i_first;
            r_busy  <= 1'b1;
            r_wv    <= i_first ? IV : r_hash;
          end
        end
        ST_LOAD: begin
          if (w_whs) begin
            if (r_t == 6'd15) begin
              r_state  <= ST_ROUND;
              r_t      <= '0;
              r_wready <= 1'b0;
            end else begin
              r_t <= r_t + 6'd1;
            end
          end
        end
        ST_ROUND: begin
          r_wv <= w_round;
          r_t  <= r_t + 6'd1;
          if (r_t == LAST_ROUND) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_hash   <= w_final;
          r_t      <= '0;
          r_dvalid <= 1'b1;
          r_state  <= ST_OUT;
        end
        ST_OUT: begin
          if (w_dhs) begin
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_wready <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wready <= 1'b0;
          r_dvalid <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_wready = r_wready;
  assign o_dvalid = r_dvalid;
  assign o_busy   = r_busy;
  assign o_digest = r_hash;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl against a plain FIPS 180-4 model.
module tb_sha256_block_ctrl;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         i_wvalid = 1'b0;
  logic         o_wready;
  logic [31:0]  i_wdata = '0;
  logic         i_first = 1'b0;
  logic         o_dvalid;
  logic         i_dready = 1'b0;
  logic [255:0] o_digest;
  logic         o_busy;

  int vectors = 0;
  int miscompares = 0;

  localparam int LATENCY = 66;
  localparam logic [255:0] IV_REF  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [255:0] h_model;

  sha256_block_ctrl #(.NUM_ROUNDS(64)) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .i_wvalid (i_wvalid),
    .o_wready (o_wready),
    .i_wdata  (i_wdata),
    .i_first  (i_first),
    .o_dvalid (o_dvalid),
    .i_dready (i_dready),
    .o_digest (o_digest),
    .o_busy   (o_busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression of one block with a fully expanded schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] m [16]);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KREF[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // Entered and left on a falling edge.
  task automatic do_reset(input string tag);
    ARESETN  = 1'b0;
    i_wvalid = 1'b0;
    i_dready = 1'b0;
    #1;
    chk({tag, "_rst_wready"}, o_wready, 0);
    chk({tag, "_rst_dvalid"}, o_dvalid, 0);
    chk({tag, "_rst_busy"}, o_busy, 0);
    chk({tag, "_rst_digest"}, o_digest, IV_REF);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk({tag, "_wready_after_rst"}, o_wready, 1);
    h_model = IV_REF;
  endtask

  // Streams 16 words; i_first is randomised on words 1..15 since it must be ignored.
  task automatic send_block(input logic [31:0] m [16], input bit first, input int gap_pct,
                            input string tag, output bit ok);
    int i = 0;
    int cycles = 0;
    bit hs;
    i_dready = 1'b0;
    while (i < 16 && cycles < 400) begin
      i_wvalid = ($urandom_range(99) >= gap_pct);
      i_wdata  = i_wvalid ? m[i] : $urandom;
      i_first  = (i == 0) ? first : 1'($urandom);
      hs = i_wvalid && o_wready;
      @(negedge ACLK);
      cycles++;
      if (hs) i++;
    end
    ok = (i == 16);
    if (!ok) chk({tag, "_load_timeout"}, i, 16);
    else if (gap_pct == 0) chk({tag, "_accept_cycles"}, cycles, 16);
  endtask

  // Waits for the digest (latency counted from the 16th word's cycle), holds it hold cycles.
  task automatic take_digest(input int hold, input logic [255:0] exp, input string tag);
    int  lat = 1;
    bit  got = 0;
    while (lat < 200) begin
      if (o_dvalid) begin
        got = 1;
        break;
      end
      chk({tag, "_wready_busy"}, o_wready, 0);
      chk({tag, "_busy"}, o_busy, 1);
      i_wvalid = 1'($urandom);
      i_wdata  = $urandom;
      i_first  = 1'($urandom);
      i_dready = (hold == 0);
      @(negedge ACLK);
      lat++;
    end
    i_wvalid = 1'b0;
    if (!got) begin
      chk({tag, "_dvalid_timeout"}, 0, 1);
      i_dready = 1'b0;
      return;
    end
    chk({tag, "_latency"}, lat, LATENCY);
    chk({tag, "_digest"}, o_digest, exp);
    for (int k = 0; k < hold; k++) begin
      i_dready = 1'b0;
      @(negedge ACLK);
      chk({tag, "_hold_dvalid"}, o_dvalid, 1);
      chk({tag, "_hold_digest"}, o_digest, exp);
      chk({tag, "_hold_wready"}, o_wready, 0);
    end
    i_dready = 1'b1;
    @(negedge ACLK);
    i_dready = 1'b0;
    chk({tag, "_post_dvalid"}, o_dvalid, 0);
    chk({tag, "_post_wready"}, o_wready, 1);
    chk({tag, "_post_busy"}, o_busy, 0);
  endtask

  task automatic run_block(input logic [31:0] m [16], input bit first, input int gap_pct,
                           input int hold, input logic [255:0] exp, input string tag);
    bit ok;
    send_block(m, first, gap_pct, tag, ok);
    if (ok) take_digest(hold, exp, tag);
    $display("block %s first=%0d gap=%0d hold=%0d exp=%0h", tag, first, gap_pct, hold, exp);
  endtask

  initial begin
    logic [31:0]  abc  [16];
    logic [31:0]  two1 [16];
    logic [31:0]  two2 [16];
    logic [31:0]  rnd  [16];
    logic [255:0] mid;
    logic [255:0] exp;
    bit           first;
    bit           ok;

    for (int i = 0; i < 16; i++) begin
      abc[i]  = '0;
      two2[i] = '0;
    end
    abc[0]   = 32'h61626380;
    abc[15]  = 32'h00000018;
    two1     = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2[15] = 32'h000001c0;

    @(negedge ACLK);
    do_reset("por");

    // Single "abc" block.
    run_block(abc, 1'b1, 0, 0, ABC_DIG, "abc");
    h_model = ABC_DIG;

    // Two-block message, intermediate digest from the model.
    mid = compress(IV_REF, two1);
    run_block(two1, 1'b1, 0, 2, mid, "two_b1");
    run_block(two2, 1'b0, 0, 0, TWO_DIG, "two_b2");
    h_model = TWO_DIG;

    // Backpressure on both sides.
    run_block(abc, 1'b1, 40, 20, ABC_DIG, "bp");
    h_model = ABC_DIG;

    // Reset around round 30, then continue-mode block must chain from IV.
    send_block(abc, 1'b1, 0, "abort", ok);
    repeat (30) begin
      @(negedge ACLK);
      chk("abort_no_dvalid", o_dvalid, 0);
    end
    do_reset("mid");
    run_block(abc, 1'b0, 0, 0, ABC_DIG, "after_rst");
    h_model = ABC_DIG;

    // Back-to-back with same-cycle digest acceptance.
    run_block(abc, 1'b1, 0, 0, ABC_DIG, "b2b_1");
    run_block(abc, 1'b1, 0, 0, ABC_DIG, "b2b_2");
    h_model = ABC_DIG;

    // Random blocks with random chaining, gaps and digest hold-off.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      first = 1'($urandom);
      exp = compress(first ? IV_REF : h_model, rnd);
      run_block(rnd, first, $urandom_range(50), $urandom_range(4), exp, $sformatf("rnd%0d", n));
      h_model = exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
